// File: rtl/instr_mem_ctrl_pkg.sv
// Shared definitions for the instruction memory controller: FSM encoding
// and default geometry of the instruction store.
package instr_mem_ctrl_pkg;

    localparam int DEF_PROG_CTR_WID = 10;
    localparam int DEF_INSTR_WID    = 16;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/instr_fetch_pipe.sv
// RUN-mode fetch stage: issues reads for the core and presents the returned
// word with a valid flag exactly one cycle after the request.
module instr_fetch_pipe
    import instr_mem_ctrl_pkg::*;
#(
    parameter int PROG_CTR_WID = DEF_PROG_CTR_WID,
    parameter int INSTR_WID    = DEF_INSTR_WID
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_run,
    input  logic                    i_reload,
    input  logic                    i_fetch_req,
    input  logic [PROG_CTR_WID-1:0] i_prog_ctr,
    input  logic [INSTR_WID-1:0]    i_mem_rdata,
    output logic                    o_rd_en,
    output logic [PROG_CTR_WID-1:0] o_rd_addr,
    output logic [INSTR_WID-1:0]    o_instr_out,
    output logic                    o_instr_valid
);

    logic                 w_issue;
    logic                 r_valid;
    logic [INSTR_WID-1:0] r_hold;

    // A reload request takes priority over a fetch in the same cycle, so
    // the read is suppressed and no word comes back for it.
    assign w_issue   = i_run & i_fetch_req & ~i_reload;
    assign o_rd_en   = w_issue;
    assign o_rd_addr = i_prog_ctr;

    // Track which cycles carry a returned word, and remember the last word
    // so instr_out holds steady on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_valid <= w_issue;
            if (r_valid) begin
                r_hold <= i_mem_rdata;
            end
        end
    end

    // The memory's own output register supplies the data in the cycle after
    // the request; pass it straight through then, otherwise show the held word.
    assign o_instr_out   = r_valid ? i_mem_rdata : r_hold;
    assign o_instr_valid = r_valid;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: boot-loads the program from a valid/ready
// stream starting at address 0, then serves core fetches from the same port.
module instr_mem_ctrl
    import instr_mem_ctrl_pkg::*;
#(
    parameter int PROG_CTR_WID = DEF_PROG_CTR_WID,
    parameter int INSTR_WID    = DEF_INSTR_WID
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [INSTR_WID-1:0]    ld_data,
    input  logic                    ld_last,
    input  logic                    reload,
    input  logic [PROG_CTR_WID-1:0] prog_ctr,
    input  logic                    fetch_req,
    output logic [INSTR_WID-1:0]    instr_out,
    output logic                    instr_valid,
    output logic                    core_stall,
    output logic                    boot_done,
    output logic [PROG_CTR_WID:0]   ld_count,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [PROG_CTR_WID-1:0] mem_addr,
    output logic [INSTR_WID-1:0]    mem_wdata,
    input  logic [INSTR_WID-1:0]    mem_rdata
);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [PROG_CTR_WID-1:0] r_wr_ptr;
    logic [PROG_CTR_WID:0]   r_ld_count;

    logic                    w_in_load;
    logic                    w_in_run;
    logic                    w_xfer;
    logic                    w_wrap;
    logic                    w_reload_run;
    logic                    w_rd_en;
    logic [PROG_CTR_WID-1:0] w_rd_addr;

    // The loader is held off while reset is asserted so no write can slip
    // into memory before the controller is out of reset.
    assign w_in_load    = (r_state == ST_LOAD) & ~rst;
    assign w_in_run     = (r_state == ST_RUN);
    assign w_xfer       = ld_valid & w_in_load;
    assign w_wrap       = (r_wr_ptr == {PROG_CTR_WID{1'b1}});
    assign w_reload_run = w_in_run & reload;

    instr_fetch_pipe #(
        .PROG_CTR_WID (PROG_CTR_WID),
        .INSTR_WID    (INSTR_WID)
    ) u_fetch (
        .clk           (clk),
        .rst           (rst),
        .i_run         (w_in_run),
        .i_reload      (reload),
        .i_fetch_req   (fetch_req),
        .i_prog_ctr    (prog_ctr),
        .i_mem_rdata   (mem_rdata),
        .o_rd_en       (w_rd_en),
        .o_rd_addr     (w_rd_addr),
        .o_instr_out   (instr_out),
        .o_instr_valid (instr_valid)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake/status outputs. A write into the top address
    // ends the load even without ld_last so address 0 is never overwritten.
    always_comb begin
        w_next_state = r_state;
        ld_ready     = 1'b0;
        core_stall   = 1'b1;
        boot_done    = 1'b0;
        case (r_state)
            ST_LOAD: begin
                ld_ready = w_in_load;
                if (w_xfer && (ld_last || w_wrap)) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                boot_done  = 1'b1;
                core_stall = reload;
                if (reload) begin
                    w_next_state = ST_LOAD;
                end
            end
            default: begin
                w_next_state = ST_LOAD;
            end
        endcase
    end

    // Write pointer and load counter advance on each accepted word and
    // restart from zero when RUN hands control back to the loader.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_ld_count <= '0;
        end else if (w_reload_run) begin
            r_wr_ptr   <= '0;
            r_ld_count <= '0;
        end else if (w_xfer) begin
            r_wr_ptr   <= r_wr_ptr + 1'b1;
            r_ld_count <= r_ld_count + 1'b1;
        end
    end

    assign ld_count = r_ld_count;

    // Single memory port: loader writes in LOAD, core reads in RUN; the two
    // never coincide because they are qualified by different states.
    assign mem_en    = w_xfer | w_rd_en;
    assign mem_we    = w_xfer;
    assign mem_addr  = w_xfer ? r_wr_ptr : w_rd_addr;
    assign mem_wdata = w_xfer ? ld_data : '0;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl: a 10-bit instance exercises loading,
// fetching, reload and reset; a 3-bit instance exercises the address wrap.
module tb_instr_mem_ctrl;

    logic clk;
    logic rst;

    // Signals for the default-width instance
    logic        ldValidA, ldReadyA, ldLastA, reloadA, fetchReqA;
    logic [15:0] ldDataA, instrOutA, memWdataA, memRdataA;
    logic [9:0]  progCtrA, memAddrA;
    logic [10:0] ldCountA;
    logic        instrValidA, coreStallA, bootDoneA, memEnA, memWeA;
    logic [15:0] memA [0:1023];

    // Signals for the 3-bit-address instance
    logic        ldValidB, ldReadyB, ldLastB, reloadB, fetchReqB;
    logic [15:0] ldDataB, instrOutB, memWdataB, memRdataB;
    logic [2:0]  progCtrB, memAddrB;
    logic [3:0]  ldCountB;
    logic        instrValidB, coreStallB, bootDoneB, memEnB, memWeB;
    logic [15:0] memB [0:7];

    int nVectors;
    int nMiscompares;

    instr_mem_ctrl #(.PROG_CTR_WID(10), .INSTR_WID(16)) dutA (
        .clk(clk), .rst(rst),
        .ld_valid(ldValidA), .ld_ready(ldReadyA), .ld_data(ldDataA), .ld_last(ldLastA),
        .reload(reloadA), .prog_ctr(progCtrA), .fetch_req(fetchReqA),
        .instr_out(instrOutA), .instr_valid(instrValidA), .core_stall(coreStallA),
        .boot_done(bootDoneA), .ld_count(ldCountA),
        .mem_en(memEnA), .mem_we(memWeA), .mem_addr(memAddrA),
        .mem_wdata(memWdataA), .mem_rdata(memRdataA)
    );

    instr_mem_ctrl #(.PROG_CTR_WID(3), .INSTR_WID(16)) dutB (
        .clk(clk), .rst(rst),
        .ld_valid(ldValidB), .ld_ready(ldReadyB), .ld_data(ldDataB), .ld_last(ldLastB),
        .reload(reloadB), .prog_ctr(progCtrB), .fetch_req(fetchReqB),
        .instr_out(instrOutB), .instr_valid(instrValidB), .core_stall(coreStallB),
        .boot_done(bootDoneB), .ld_count(ldCountB),
        .mem_en(memEnB), .mem_we(memWeB), .mem_addr(memAddrB),
        .mem_wdata(memWdataB), .mem_rdata(memRdataB)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory models with a registered read port
    always @(posedge clk) begin
        if (memEnA) begin
            if (memWeA) memA[memAddrA] <= memWdataA;
            else        memRdataA <= memA[memAddrA];
        end
        if (memEnB) begin
            if (memWeB) memB[memAddrB] <= memWdataB;
            else        memRdataB <= memB[memAddrB];
        end
    end

    // One comparison point
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVectors++;
        assert (obs === exp)
        else begin
            nMiscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, then let combinational outputs settle
    task automatic applyStimulus();
        @(negedge clk);
    endtask

    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        rst = 1'b1;
        ldValidA = 0; ldLastA = 0; ldDataA = 0; reloadA = 0; fetchReqA = 0; progCtrA = 0;
        ldValidB = 0; ldLastB = 0; ldDataB = 0; reloadB = 0; fetchReqB = 0; progCtrB = 0;
        #1;
        // Reset values
        checkOutput("rst_ld_ready",    ldReadyA, 0);
        checkOutput("rst_core_stall",  coreStallA, 1);
        checkOutput("rst_boot_done",   bootDoneA, 0);
        checkOutput("rst_instr_valid", instrValidA, 0);
        checkOutput("rst_instr_out",   instrOutA, 0);
        checkOutput("rst_mem_en",      memEnA, 0);
        checkOutput("rst_mem_we",      memWeA, 0);
        checkOutput("rst_ld_count",    ldCountA, 0);

        applyStimulus();
        rst = 1'b0;

        // Load four words with ld_last on the fourth
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            ldValidA = 1; ldDataA = 16'hA001 + 16'(i); ldLastA = (i == 3);
            #1;
            checkOutput("ld4_ready", ldReadyA, 1);
            checkOutput("ld4_stall", coreStallA, 1);
            checkOutput("ld4_we",    memWeA, 1);
            checkOutput("ld4_addr",  memAddrA, i);
            checkOutput("ld4_wdata", memWdataA, 16'hA001 + i);
        end
        applyStimulus();
        ldValidA = 0; ldLastA = 0;
        #1;
        checkOutput("drain_ready", ldReadyA, 0);
        checkOutput("drain_stall", coreStallA, 1);
        checkOutput("drain_en",    memEnA, 0);
        checkOutput("drain_boot",  bootDoneA, 0);
        checkOutput("drain_count", ldCountA, 4);

        // RUN: back-to-back fetches of 0..3, with a stray ld_valid that must be ignored
        applyStimulus();
        #1;
        checkOutput("run_boot",  bootDoneA, 1);
        checkOutput("run_stall", coreStallA, 0);
        checkOutput("run_count", ldCountA, 4);
        for (int i = 0; i < 4; i++) begin
            fetchReqA = 1; progCtrA = 10'(i); ldValidA = (i == 1);
            #1;
            checkOutput("fetch_en",   memEnA, 1);
            checkOutput("fetch_we",   memWeA, 0);
            checkOutput("fetch_addr", memAddrA, i);
            if (i > 0) begin
                checkOutput("fetch_valid", instrValidA, 1);
                checkOutput("fetch_instr", instrOutA, 16'hA000 + i);
            end
            applyStimulus();
        end
        fetchReqA = 0; ldValidA = 0;
        #1;
        checkOutput("last_valid", instrValidA, 1);
        checkOutput("last_instr", instrOutA, 16'hA004);
        checkOutput("idle_en",    memEnA, 0);
        applyStimulus();
        #1;
        checkOutput("idle_valid", instrValidA, 0);
        checkOutput("hold_instr", instrOutA, 16'hA004);

        // Reload together with a fetch: reload wins, no read issued
        fetchReqA = 1; progCtrA = 10'd2; reloadA = 1;
        #1;
        checkOutput("rl_en",    memEnA, 0);
        checkOutput("rl_stall", coreStallA, 1);
        applyStimulus();
        fetchReqA = 0; reloadA = 0;
        #1;
        checkOutput("rl_valid", instrValidA, 0);
        checkOutput("rl_count", ldCountA, 0);
        checkOutput("rl_ready", ldReadyA, 1);
        checkOutput("rl_boot",  bootDoneA, 0);

        // Load with ld_valid toggling; writes only on valid cycles, contiguous from 0
        for (int i = 0; i < 5; i++) begin
            if (i > 0) applyStimulus();
            ldValidA = (i % 2 == 0); ldDataA = 16'hB001 + 16'(i / 2); ldLastA = (i == 4);
            #1;
            checkOutput("tog_we",    memWeA, (i % 2 == 0));
            checkOutput("tog_stall", coreStallA, 1);
            if (i % 2 == 0) checkOutput("tog_addr", memAddrA, i / 2);
        end
        applyStimulus();
        ldValidA = 0; ldLastA = 0;
        #1;
        checkOutput("tog_drain_stall", coreStallA, 1);
        checkOutput("tog_count",       ldCountA, 3);
        applyStimulus();
        fetchReqA = 1; progCtrA = 10'd1;
        #1;
        checkOutput("tog_run_stall", coreStallA, 0);
        applyStimulus();
        fetchReqA = 0;
        #1;
        checkOutput("tog_fetch_valid", instrValidA, 1);
        checkOutput("tog_fetch_instr", instrOutA, 16'hB002);

        // Reload, write two words, then assert reset mid-load
        reloadA = 1;
        applyStimulus();
        reloadA = 0;
        for (int i = 0; i < 2; i++) begin
            ldValidA = 1; ldDataA = 16'hC001 + 16'(i); ldLastA = 0;
            #1;
            checkOutput("pre_rst_addr", memAddrA, i);
            applyStimulus();
        end
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_ready", ldReadyA, 0);
        checkOutput("mid_rst_en",    memEnA, 0);
        checkOutput("mid_rst_we",    memWeA, 0);
        checkOutput("mid_rst_count", ldCountA, 0);
        checkOutput("mid_rst_stall", coreStallA, 1);
        checkOutput("mid_rst_instr", instrOutA, 0);
        applyStimulus();
        rst = 1'b0;
        ldValidA = 1; ldDataA = 16'hD001; ldLastA = 1;
        #1;
        checkOutput("post_rst_addr", memAddrA, 0);
        checkOutput("post_rst_we",   memWeA, 1);
        applyStimulus();
        ldValidA = 0; ldLastA = 0;
        applyStimulus();
        fetchReqA = 1; progCtrA = 10'd0;
        #1;
        checkOutput("post_rst_count", ldCountA, 1);
        applyStimulus();
        progCtrA = 10'd1;
        #1;
        checkOutput("post_rst_instr0", instrOutA, 16'hD001);
        applyStimulus();
        fetchReqA = 0;
        #1;
        checkOutput("untouched_instr1", instrOutA, 16'hC002);

        // Narrow instance: eight words with no ld_last fill memory and end the load
        for (int i = 0; i < 8; i++) begin
            ldValidB = 1; ldDataB = 16'hE000 + 16'(i); ldLastB = 0;
            #1;
            checkOutput("wrap_addr", memAddrB, i);
            applyStimulus();
        end
        ldValidB = 1; ldDataB = 16'hEEEE;
        #1;
        checkOutput("wrap_drain_en",    memEnB, 0);
        checkOutput("wrap_drain_ready", ldReadyB, 0);
        checkOutput("wrap_count",       ldCountB, 8);
        applyStimulus();
        ldValidB = 0;
        fetchReqB = 1; progCtrB = 3'd0;
        #1;
        checkOutput("wrap_boot", bootDoneB, 1);
        applyStimulus();
        fetchReqB = 0;
        #1;
        checkOutput("wrap_fetch_valid", instrValidB, 1);
        checkOutput("wrap_fetch_instr", instrOutB, 16'hE000);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
